// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline-control state encodings and constants.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_ERR} state_e;
  localparam logic [31:0] NOP = 32'h0000_0020;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline and stall/flush/status outputs back to it.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] ID_rs, ID_rt, EX_wreg;
  logic ID_use_rt, EX_memtoreg, EX_br_taken, dmem_req, dmem_ack, halt_req, resume_req;
  logic pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted, bus_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport slave (
    input ID_rs, ID_rt, ID_use_rt, EX_memtoreg, EX_wreg, EX_br_taken, dmem_req, dmem_ack, halt_req, resume_req,
    output pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted, bus_err, stall_cnt, flush_cnt
  );
  modport master (
    output ID_rs, ID_rt, ID_use_rt, EX_memtoreg, EX_wreg, EX_br_taken, dmem_req, dmem_ack, halt_req, resume_req,
    input pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
    input IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, halted, bus_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping stall-cycle and branch-flush counters.
module hazard_perf_cnt #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(stall_inc_i);
      flush_q <= flush_q + CNT_W'(flush_inc_i);
    end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generator with debug halt/drain, dmem watchdog and perf counters.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int DRAIN   = 3,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);
  state_e     fsm_q, fsm_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] drain_q, drain_d;
  logic       bus_err_q, bus_err_d;
  logic       dw, lu, br, act, drn, frz;
  assign dw  = hz.dmem_req & ~hz.dmem_ack;
  assign lu  = hz.EX_memtoreg & (hz.EX_wreg != 5'd0) &
               ((hz.EX_wreg == hz.ID_rs) | (hz.ID_use_rt & (hz.EX_wreg == hz.ID_rt)));
  assign br  = hz.EX_br_taken;
  assign drn = fsm_q == S_DRAIN;
  assign act = (fsm_q == S_RUN) | drn;
  assign frz = (fsm_q == S_HALT) | (fsm_q == S_ERR);
  // Outputs are held low while reset is asserted, whatever the inputs are doing.
  assign hz.pc_stall     = rst_n & (frz | act & (dw | drn | ~br & lu));
  assign hz.IF_ID_stall  = rst_n & (frz | act & (dw | ~br & lu));
  assign hz.ID_EX_stall  = rst_n & (frz | act & dw);
  assign hz.EX_MEM_stall = rst_n & (frz | act & dw);
  assign hz.MEM_WB_stall = rst_n & frz;
  assign hz.IF_ID_flush  = rst_n & act & ~dw & (br | drn & ~lu);
  assign hz.ID_EX_flush  = rst_n & act & ~dw & (br | lu);
  assign hz.EX_MEM_flush = 1'b0;
  assign hz.MEM_WB_flush = rst_n & act & dw;
  assign hz.halted       = rst_n & (fsm_q == S_HALT);
  assign hz.bus_err      = bus_err_q;
  always_comb begin
    fsm_d     = fsm_q;
    wait_d    = act & dw ? wait_q + 8'd1 : 8'd0;
    drain_d   = drain_q;
    bus_err_d = bus_err_q;
    if (act & dw & (wait_q == 8'(TIMEOUT - 1))) begin
      fsm_d     = S_ERR;
      bus_err_d = 1'b1;
    end else if ((fsm_q == S_RUN) & hz.halt_req & ~dw & ~br & ~lu) begin
      fsm_d   = S_DRAIN;
      drain_d = 2'd0;
    end else if (drn & ~dw) begin
      drain_d = drain_q + 2'd1;
      fsm_d   = drain_q == 2'(DRAIN - 1) ? S_HALT : S_DRAIN;
    end else if ((fsm_q == S_HALT) & hz.resume_req) begin
      fsm_d = S_RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm_q     <= S_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      bus_err_q <= bus_err_d;
    end
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_inc_i (hz.pc_stall),
    .flush_inc_i (hz.IF_ID_flush & br),
    .stall_cnt_o (hz.stall_cnt),
    .flush_cnt_o (hz.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;
  localparam int TIMEOUT = 8, DRAIN = 3, CNT_W = 32;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_ERR = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(CNT_W)) hz();
  hazard_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN(DRAIN), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  int checks = 0, errors = 0;
  int mode = M_RUN, waited = 0, drained = 0;
  bit berr = 0, m_dw, m_lu, m_br;
  logic [CNT_W-1:0] scnt = '0, fcnt = '0, base;
  logic [8:0] e;
  // bit order: pc, IF_ID/ID_EX/EX_MEM/MEM_WB stall, IF_ID/ID_EX/EX_MEM/MEM_WB flush
  function automatic logic [8:0] dut_vec();
    return {hz.pc_stall, hz.IF_ID_stall, hz.ID_EX_stall, hz.EX_MEM_stall, hz.MEM_WB_stall,
            hz.IF_ID_flush, hz.ID_EX_flush, hz.EX_MEM_flush, hz.MEM_WB_flush};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    hz.ID_rs = 0; hz.ID_rt = 0; hz.ID_use_rt = 0; hz.EX_memtoreg = 0; hz.EX_wreg = 0;
    hz.EX_br_taken = 0; hz.dmem_req = 0; hz.dmem_ack = 0; hz.halt_req = 0; hz.resume_req = 0;
  endtask
  task automatic load_use();
    hz.EX_memtoreg = 1; hz.EX_wreg = 2; hz.ID_rs = 3; hz.ID_rt = 2; hz.ID_use_rt = 1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      mode = M_RUN; waited = 0; drained = 0; berr = 0; scnt = '0; fcnt = '0;
      check("rst_ctrl", dut_vec(), 0);
      check("rst_halted", hz.halted, 0);
      check("rst_bus_err", hz.bus_err, 0);
      check("rst_stall_cnt", hz.stall_cnt, 0);
      check("rst_flush_cnt", hz.flush_cnt, 0);
    end else begin
      m_dw = hz.dmem_req && !hz.dmem_ack;
      m_br = hz.EX_br_taken;
      m_lu = hz.EX_memtoreg && hz.EX_wreg != 0 &&
             (hz.EX_wreg == hz.ID_rs || (hz.ID_use_rt && hz.EX_wreg == hz.ID_rt));
      if (mode >= M_HALT) e = 9'b1_1111_0000;
      else if (m_dw)      e = 9'b1_1110_0001;
      else if (m_br)      e = mode == M_DRAIN ? 9'b1_0000_1100 : 9'b0_0000_1100;
      else if (m_lu)      e = 9'b1_1000_0100;
      else if (mode == M_DRAIN) e = 9'b1_0000_1000;
      else e = 9'b0;
      check("ctrl", dut_vec(), e);
      check("halted", hz.halted, mode == M_HALT);
      check("bus_err", hz.bus_err, berr);
      check("stall_cnt", hz.stall_cnt, scnt);
      check("flush_cnt", hz.flush_cnt, fcnt);
      scnt += CNT_W'(e[8]);
      fcnt += CNT_W'(e[3] && m_br);
      if (mode <= M_DRAIN) begin
        waited = m_dw ? waited + 1 : 0;
        if (waited == TIMEOUT) begin
          mode = M_ERR; berr = 1;
        end else if (mode == M_RUN) begin
          if (hz.halt_req && !m_dw && !m_br && !m_lu) begin mode = M_DRAIN; drained = 0; end
        end else if (!m_dw) begin
          drained++;
          if (drained == DRAIN) mode = M_HALT;
        end
      end else if (mode == M_HALT && hz.resume_req) mode = M_RUN;
    end
  end
  initial begin
    idle();
    @(negedge clk);
    check("reset_vec", dut_vec(), 0);
    step(); rst_n = 1;
    load_use();
    @(negedge clk); check("lu_vec", dut_vec(), 9'b1_1000_0100);
    step(); idle();
    @(negedge clk); check("lu_after", dut_vec(), 0); check("lu_stall_cnt", hz.stall_cnt, 1);
    step(); hz.EX_memtoreg = 1; hz.EX_wreg = 0; hz.ID_rs = 0;
    @(negedge clk); check("lu_r0", dut_vec(), 0);
    step(); hz.EX_wreg = 5; hz.ID_rt = 5; hz.ID_rs = 1; hz.ID_use_rt = 0;
    @(negedge clk); check("lu_no_rt", dut_vec(), 0);
    step(); idle(); hz.EX_br_taken = 1;
    @(negedge clk); check("br_vec", dut_vec(), 9'b0_0000_1100); check("br_cnt0", hz.flush_cnt, 0);
    step(); idle();
    @(negedge clk); check("br_cnt1", hz.flush_cnt, 1);
    step(); load_use(); hz.EX_br_taken = 1;
    @(negedge clk); check("br_over_lu", dut_vec(), 9'b0_0000_1100);
    step(); idle(); base = hz.stall_cnt; hz.dmem_req = 1; hz.EX_br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("dw_vec", dut_vec(), 9'b1_1110_0001);
      step();
    end
    hz.dmem_ack = 1;
    @(negedge clk); check("dw_ack_br", dut_vec(), 9'b0_0000_1100);
    step(); idle();
    @(negedge clk); check("dw_stall_cnt", hz.stall_cnt - base, 4); check("dw_flush_cnt", hz.flush_cnt, 3);
    step(); load_use(); hz.halt_req = 1;
    @(negedge clk); check("halt_defer", dut_vec(), 9'b1_1000_0100); check("halt_defer_h", hz.halted, 0);
    step(); idle(); hz.halt_req = 1;
    @(negedge clk); check("halt_accept", dut_vec(), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk); check("drain_vec", dut_vec(), 9'b1_0000_1000); check("drain_h", hz.halted, 0);
    end
    step();
    @(negedge clk); check("halted", hz.halted, 1); check("halt_vec", dut_vec(), 9'b1_1111_0000);
    step(); hz.resume_req = 1;
    @(negedge clk); check("resume_cyc", hz.halted, 1);
    step(); idle();
    @(negedge clk); check("resumed_vec", dut_vec(), 0); check("resumed_h", hz.halted, 0);
    step(); hz.halt_req = 1;
    step(); hz.dmem_req = 1;
    @(negedge clk); check("drain_dw", dut_vec(), 9'b1_1110_0001);
    step(); rst_n = 0; #1;
    check("rst_mid_vec", dut_vec(), 0); check("rst_mid_h", hz.halted, 0);
    check("rst_mid_scnt", hz.stall_cnt, 0); check("rst_mid_fcnt", hz.flush_cnt, 0);
    step(); rst_n = 1; idle();
    for (int n = 0; n < 3000; n++) begin
      step();
      if (mode == M_ERR) begin
        rst_n = 0; step(); rst_n = 1;
      end
      hz.ID_rs = 5'($urandom_range(0, 3)); hz.ID_rt = 5'($urandom_range(0, 3));
      hz.EX_wreg = 5'($urandom_range(0, 3)); hz.ID_use_rt = 1'($urandom_range(0, 1));
      hz.EX_memtoreg = $urandom_range(0, 99) < 40;
      hz.EX_br_taken = $urandom_range(0, 99) < 15;
      hz.dmem_req = $urandom_range(0, 99) < 30;
      hz.dmem_ack = 1'($urandom_range(0, 1));
      hz.resume_req = mode == M_HALT && $urandom_range(0, 99) < 30;
      if (mode == M_HALT) hz.halt_req = 1'($urandom_range(0, 1));
      else if (!hz.halt_req) hz.halt_req = $urandom_range(0, 99) < 4;
    end
    step(); idle(); rst_n = 0;
    step(); rst_n = 1; hz.dmem_req = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk); check("wd_wait", hz.bus_err, 0); check("wd_vec", dut_vec(), 9'b1_1110_0001);
      step();
    end
    @(negedge clk); check("wd_err", hz.bus_err, 1); check("wd_stuck", dut_vec(), 9'b1_1111_0000);
    step(); hz.resume_req = 1;
    step(); idle();
    @(negedge clk); check("err_hold", dut_vec(), 9'b1_1111_0000); check("err_sticky", hz.bus_err, 1);
    step(); rst_n = 0; #1;
    check("err_rst", hz.bus_err, 0);
    step(); rst_n = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
